serial_tx: RTL and testbench
============================

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, which sets the clock cycles each serial bit is held (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port set, input, 8 bits: parallel byte to transmit.
REQ-005 SHALL have port start, input, 1 bit: request to transmit set, level-sampled.
REQ-006 SHALL have port serial_out, output reg, 1 bit: serial line, idle high.
REQ-007 SHALL have port busy, output reg, 1 bit: high while a frame is in progress.
REQ-008 SHALL have port done, output reg, 1 bit: one-cycle pulse at frame end.
REQ-009 SHALL have port out_light, output reg, 8 bits: live view of the TX shift register.
REQ-010 SHALL have ports numa and numb, output reg, 7 bits each: active-low 7-seg codes for the high and low nibbles of the latched byte.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-012 In IDLE with start=1 at posedge: latch set into tx_byte and out_light, then busy<=1, serial_out<=0, go to START.
REQ-013 In IDLE with start=0: serial_out=1, busy=0, and all registers hold.
REQ-014 Each bit SHALL be held exactly CLKS_PER_BIT cycles, timed by a bit-cycle counter that resets on each bit boundary.
REQ-015 START->DATA: serial_out<=out_light[0]; DATA sends 8 bits LSB first; on each DATA bit boundary out_light<={1'b0,out_light[7:1]}.
REQ-016 After the 8th data bit: go to STOP (or PARITY if the macro is defined); STOP drives serial_out=1 for CLKS_PER_BIT cycles.
REQ-017 At STOP end: go to IDLE, busy<=0, done<=1 for exactly one cycle.
REQ-018 Frame busy time SHALL be 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
REQ-019 start while busy SHALL be ignored, with no queuing.
REQ-020 start held high continuously SHALL produce back-to-back frames, each re-latching set in the IDLE cycle after done; there is at least one idle-high cycle between frames.
REQ-021 set changes while busy SHALL NOT affect the current frame.
REQ-022 numa/numb SHALL encode tx_byte[7:4] and tx_byte[3:0], registered, and are valid one cycle after the latch.
REQ-023 The hex table SHALL be bit order g..a: 0=1000000, 1=1111001, 5=0010010, 8=0000000, A=0001000, C=1000110, F=0001110, using the team standard table for the remaining digits.

Reset
REQ-024 rst_n=0 at posedge SHALL force: state=IDLE, serial_out=1, busy=0, done=0, out_light=0, tx_byte=0, bit counters=0, numa=numb=1000000.
REQ-025 Reset mid-frame SHALL abort the frame with no done pulse; the line returns high on that edge.
REQ-026 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-027 Macro SERIAL_TX_PARITY_EN, when defined, SHALL add state PARITY after DATA, transmitting the even-parity bit (XOR of tx_byte) for CLKS_PER_BIT cycles.
REQ-028 Without SERIAL_TX_PARITY_EN, SHALL go DATA->STOP directly, with no parity logic synthesized.

Verification
REQ-029 Reset: rst_n=0 for 2 cycles, then 1 -> serial_out=1, busy=0, done=0, out_light=00, numa=numb=1000000.
REQ-030 CLKS_PER_BIT=4, set=A5, start pulse -> serial_out sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy high 40 cycles; single done pulse; numa=0001000, numb=0010010.
REQ-031 Parity build, set=A5 -> parity bit 0; set=07 -> parity bit 1; busy is 44 cycles.
REQ-032 start re-pulsed mid-frame with set changed to 3C -> current frame unchanged, no second frame.
REQ-033 rst_n=0 during DATA bit 3 -> next edge serial_out=1, busy=0, no done pulse; a subsequent start sends a full, correct frame.
REQ-034 start held high, set=FF then 00 -> two complete frames with a one-cycle idle-high gap; the second frame carries the value of set at the latch cycle.

Source files
------------

// File: rtl/serial_tx.sv
// serial_tx: 8N1 serial transmitter with latched byte and 7-seg nibble view.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit after the data bits.
module serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] set,
  input  logic       start,
  output logic       serial_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] out_light,
  output logic [6:0] numa,
  output logic [6:0] numb
);

  localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [7:0] light_q, light_d;
  logic       ser_q, ser_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [6:0] numa_q, numa_d;
  logic [6:0] numb_q, numb_d;
  logic       bit_end;

  // active-low g..a segment code for one hex digit
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign bit_end = (cnt_q == CNT_LAST);

  // next-state, bit timing and output computation
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    tx_byte_d = tx_byte_q;
    light_d   = light_q;
    ser_d     = ser_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = bit_end ? 8'd0 : cnt_q + 8'd1;
    numa_d    = seg7(tx_byte_q[7:4]);
    numb_d    = seg7(tx_byte_q[3:0]);
    unique case (state_q)
      S_IDLE: begin
        cnt_d  = 8'd0;
        bit_d  = 3'd0;
        ser_d  = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          tx_byte_d = set;
          light_d   = set;
          busy_d    = 1'b1;
          ser_d     = 1'b0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          ser_d   = light_q[0];
          bit_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          light_d = {1'b0, light_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
            ser_d   = ^tx_byte_q;
            state_d = S_PARITY;
`else
            ser_d   = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            ser_d = light_q[1];
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          ser_d   = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = 8'd0;
        ser_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      bit_q     <= 3'd0;
      tx_byte_q <= 8'd0;
      light_q   <= 8'd0;
      ser_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      numa_q    <= SEG_ZERO;
      numb_q    <= SEG_ZERO;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_byte_q <= tx_byte_d;
      light_q   <= light_d;
      ser_q     <= ser_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      numa_q    <= numa_d;
      numb_q    <= numb_d;
    end
  end

  assign serial_out = ser_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign out_light  = light_q;
  assign numa       = numa_q;
  assign numb       = numb_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: random frames checked against a per-bit frame model.
// Compile with SERIAL_TX_PARITY_EN to check the parity build.
module tb_serial_tx;

  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] set = 8'h00;
  logic       start = 1'b0;
  logic       serial_out, busy, done;
  logic [7:0] out_light;
  logic [6:0] numa, numb;

  int total = 0;
  int bad = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  serial_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .set(set), .start(start),
    .serial_out(serial_out), .busy(busy), .done(done),
    .out_light(out_light), .numa(numa), .numb(numb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // line level for bit slot idx of a frame carrying b
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef SERIAL_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic logic [7:0] exp_light(input logic [7:0] b, input int idx);
    if (idx == 0) return b;
    if (idx <= 8) return b >> (idx - 1);
    return 8'h00;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [7:0] b, input bit hold,
                           input bit noise, input int abort_at);
    int n;
    n = NBITS * CPB;
    start = 1'b1;
    set = b;
    step();
    for (int k = 0; k < n; k++) begin
      chk("ser", 32'(serial_out), 32'(exp_bit(b, k / CPB)));
      chk("busy", 32'(busy), 32'd1);
      chk("done_mid", 32'(done), 32'd0);
      chk("light", 32'(out_light), 32'(exp_light(b, k / CPB)));
      if (k == 1) begin
        chk("numa", 32'(numa), 32'(seg_tab[b[7:4]]));
        chk("numb", 32'(numb), 32'(seg_tab[b[3:0]]));
      end
      start = hold ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
      if (hold || noise) set = 8'($urandom);
      if (k == abort_at) begin
        rst_n = 1'b0;
        start = 1'b1;
        step();
        chk("rst_ser", 32'(serial_out), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_light", 32'(out_light), 32'd0);
        chk("rst_numa", 32'(numa), 32'h40);
        rst_n = 1'b1;
        start = 1'b0;
        step();
        chk("post_done", 32'(done), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_numb", 32'(numb), 32'h40);
        return;
      end
      step();
    end
    chk("end_done", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_ser", 32'(serial_out), 32'd1);
    chk("end_numa", 32'(numa), 32'(seg_tab[b[7:4]]));
    chk("end_numb", 32'(numb), 32'(seg_tab[b[3:0]]));
    if (!hold) start = 1'b0;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_ser", 32'(serial_out), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    step();
    step();
    chk("r_ser", 32'(serial_out), 32'd1);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_done", 32'(done), 32'd0);
    chk("r_light", 32'(out_light), 32'd0);
    chk("r_numa", 32'(numa), 32'h40);
    chk("r_numb", 32'(numb), 32'h40);
    rst_n = 1'b1;
    idle_check(3);

    run_frame(8'hA5, 1'b0, 1'b0, -1);
    idle_check(2);
    run_frame(8'h07, 1'b0, 1'b0, -1);
    idle_check(2);

    run_frame(8'h3C, 1'b0, 1'b1, -1);
    idle_check(CPB * 3);

    run_frame(8'h96, 1'b0, 1'b0, 4 * CPB + 1);
    idle_check(2);
    run_frame(8'h5A, 1'b0, 1'b0, -1);
    idle_check(1);

    run_frame(8'hFF, 1'b1, 1'b0, -1);
    run_frame(8'h00, 1'b1, 1'b0, -1);
    start = 1'b0;
    idle_check(2);

    for (int i = 0; i < 12; i++) begin
      run_frame(8'($urandom), 1'b0, 1'($urandom), -1);
      if (i % 3 == 0) idle_check(int'($urandom_range(1, 3)));
    end
    idle_check(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
